// File: rtl/db_multi_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package db_multi_pkg;

  // Auto-repeat phase encoding: waiting out the initial delay, then repeating at the rate.
  localparam logic PH_DELAY = 1'b0;
  localparam logic PH_RATE  = 1'b1;

  // Width of a counter that must hold values 0..max_val; never narrower than 1 bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/db_chan.sv
// Single debounce channel: 2-flop synchronizer, symmetric tick-based debounce,
// registered level plus rise/fall pulses, and optional auto-repeat press pulses.
module db_chan
  import db_multi_pkg::*;
#(
  parameter int STABLE_TICKS = 1000,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 50000,
  parameter int REPEAT_RATE  = 10000
) (
  input  logic clk,
  input  logic rstn,
  input  logic tick,
  input  logic x,
  output logic y,
  output logic rise,
  output logic fall,
  output logic press
);

  localparam int             CW       = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          s1;
  logic          xs;
  logic [CW-1:0] cnt;
  logic          flip;
  logic          rep_now;

  // Two-flop synchronizer for the asynchronous raw input.
  // NOTE: state is updated with non-blocking assignments so xs samples the old s1, giving two real stages.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      xs <= 1'b0;
    end else begin
      s1 <= x;
      xs <= s1;
    end
  end

  // y flips on the tick that completes STABLE_TICKS consecutive differing ticks.
  assign flip = (xs != y) && tick && (cnt == CNT_LAST);

  // Debounce counter, clean level, and registered edge/press pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      y     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      press <= 1'b0;
    end else begin
      rise  <= flip & xs;
      fall  <= flip & ~xs;
      press <= (flip & xs) | rep_now;
      if (xs == y) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          y   <= xs;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_rep
      localparam int            RMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
      localparam int            RW         = cnt_width(RMAX);
      localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

      logic [RW-1:0] rcnt;
      logic          phase;
      logic          rep_hit;

      // A repeat fires on the tick where the counter reaches the terminal count of the current phase.
      // NOTE: rep_hit gets a default before any branch so no latch is inferred.
      always_comb begin
        rep_hit = 1'b0;
        if (y && tick) begin
          rep_hit = (phase == PH_DELAY) ? (rcnt == DELAY_LAST) : (rcnt == RATE_LAST);
        end
      end

      // Repeat counter and phase; a low level holds both at their idle values.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rcnt  <= '0;
          phase <= PH_DELAY;
        end else if (!y) begin
          rcnt  <= '0;
          phase <= PH_DELAY;
        end else if (tick) begin
          if (rep_hit) begin
            rcnt  <= '0;
            phase <= PH_RATE;
          end else begin
            rcnt <= rcnt + RW'(1);
          end
        end
      end

      assign rep_now = rep_hit;
    end else begin : g_norep
      assign rep_now = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/db_multi.sv
// N-channel debouncer: one shared prescaler tick fanned out to N independent channels.
module db_multi
  import db_multi_pkg::*;
#(
  parameter int N            = 4,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 1000,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 50000,
  parameter int REPEAT_RATE  = 10000
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] x,
  output logic [N-1:0] y,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] press
);

  logic tick;

  generate
    if (TICK_DIV <= 1) begin : g_tick_every
      assign tick = 1'b1;
    end else begin : g_presc
      localparam int            TW    = cnt_width(TICK_DIV - 1);
      localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);

      logic [TW-1:0] tcnt;

      // Free-running prescaler 0..TICK_DIV-1.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          tcnt <= '0;
        end else if (tcnt == TLAST) begin
          tcnt <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end

      assign tick = (tcnt == TLAST);
    end
  endgenerate

  generate
    for (genvar i = 0; i < N; i++) begin : g_chan
      db_chan #(
        .STABLE_TICKS (STABLE_TICKS),
        .REPEAT_EN    (REPEAT_EN),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
      ) u_chan (
        .clk   (clk),
        .rstn  (rstn),
        .tick  (tick),
        .x     (x[i]),
        .y     (y[i]),
        .rise  (rise[i]),
        .fall  (fall[i]),
        .press (press[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_db_multi.sv
// Self-checking bench for db_multi: table-driven vectors plus an event scoreboard.
module tb_db_multi;

  localparam int N   = 2;
  localparam int ST  = 4;
  localparam int RD  = 8;
  localparam int RR  = 3;
  localparam int LAT = ST + 2;   // clean change to y with TICK_DIV = 1

  logic         clk  = 1'b0;
  logic         rstn = 1'b1;
  logic [N-1:0] x    = '0;
  logic [N-1:0] xp   = '0;

  logic [N-1:0] y, rise, fall, press;
  logic [N-1:0] y_n, rise_n, fall_n, press_n;
  logic [N-1:0] y_p, rise_p, fall_p, press_p;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int exp_rise_total = 0;
  int exp_fall_total = 0;
  int nr_cnt = 0, nf_cnt = 0, np_cnt = 0;
  int pr_cnt = 0, pf_cnt = 0, pp_cnt = 0;

  typedef enum int {EV_RISE, EV_FALL, EV_PRESS} ev_kind_t;
  typedef struct {
    int       cyc;
    int       ch;
    ev_kind_t kind;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    logic [1:0] x;
    int         hold;
    logic [1:0] y_end;
    logic [1:0] rise_m;
    logic [1:0] fall_m;
    logic [1:0] rep_m;
    int         r0, r1, r2;
  } vec_t;
  localparam int NV = 12;
  vec_t vecs[NV];

  db_multi #(.N(N), .TICK_DIV(1), .STABLE_TICKS(ST), .REPEAT_EN(1),
             .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rstn(rstn), .x(x), .y(y), .rise(rise), .fall(fall), .press(press));

  db_multi #(.N(N), .TICK_DIV(1), .STABLE_TICKS(ST), .REPEAT_EN(0),
             .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_norep (
    .clk(clk), .rstn(rstn), .x(x), .y(y_n), .rise(rise_n), .fall(fall_n), .press(press_n));

  db_multi #(.N(N), .TICK_DIV(5), .STABLE_TICKS(ST), .REPEAT_EN(1),
             .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_pre (
    .clk(clk), .rstn(rstn), .x(xp), .y(y_p), .rise(rise_p), .fall(fall_p), .press(press_p));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rng(input string name, input int val, input int lo, input int hi);
    n_checks++;
    if (val < lo || val > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, val, lo, hi, cyc);
    end
  endtask

  task automatic push(input int c, input int ch, input ev_kind_t k);
    ev_t e;
    e.cyc = c; e.ch = ch; e.kind = k;
    sb.push_back(e);
    if (k == EV_RISE) exp_rise_total++;
    if (k == EV_FALL) exp_fall_total++;
  endtask

  task automatic push_press(input int c, input int ch);
    push(c, ch, EV_RISE);
    push(c, ch, EV_PRESS);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pops the earliest expected event of this kind/channel and compares its cycle.
  task automatic match(input int ch, input ev_kind_t k, input string name);
    int best;
    best = -1;
    foreach (sb[i]) begin
      if (sb[i].ch == ch && sb[i].kind == k && (best < 0 || sb[i].cyc < sb[best].cyc)) best = i;
    end
    if (best < 0) begin
      check($sformatf("%s[%0d]_unexpected", name, ch), cyc, -1);
    end else begin
      check($sformatf("%s[%0d]_cycle", name, ch), cyc, sb[best].cyc);
      sb.delete(best);
    end
  endtask

  // Scoreboard monitor for the main DUT, sampled 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    for (int ch = 0; ch < N; ch++) begin
      if (rise[ch])  match(ch, EV_RISE, "rise");
      if (fall[ch])  match(ch, EV_FALL, "fall");
      if (press[ch]) match(ch, EV_PRESS, "press");
    end
  end

  // Pulse tallies for the no-repeat and prescaled DUTs.
  always @(posedge clk) begin
    #1;
    nr_cnt += $countones(rise_n);
    nf_cnt += $countones(fall_n);
    np_cnt += $countones(press_n);
    pr_cnt += $countones(rise_p);
    pf_cnt += $countones(fall_p);
    pp_cnt += $countones(press_p);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, r, d;

    //          x      hold  y_end  rise   fall   rep    r0  r1  r2
    vecs[0]  = '{2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00, -1, -1, -1};  // idle
    vecs[1]  = '{2'b01,  3, 2'b00, 2'b00, 2'b00, 2'b00, -1, -1, -1};  // 3-cycle glitch: rejected
    vecs[2]  = '{2'b00,  8, 2'b00, 2'b00, 2'b00, 2'b00, -1, -1, -1};
    vecs[3]  = '{2'b01,  4, 2'b00, 2'b01, 2'b00, 2'b00, -1, -1, -1};  // 4-cycle pulse: accepted
    vecs[4]  = '{2'b00, 10, 2'b00, 2'b00, 2'b01, 2'b00, -1, -1, -1};
    vecs[5]  = '{2'b01, 21, 2'b01, 2'b01, 2'b00, 2'b01, 14, 17, 20};  // hold: repeats T+8,+11,+14
    vecs[6]  = '{2'b00, 12, 2'b00, 2'b00, 2'b01, 2'b01,  2,  5, -1};  // repeats until y drops
    vecs[7]  = '{2'b11,  7, 2'b11, 2'b11, 2'b00, 2'b00, -1, -1, -1};  // both channels together
    vecs[8]  = '{2'b00,  8, 2'b00, 2'b00, 2'b11, 2'b00, -1, -1, -1};
    vecs[9]  = '{2'b10,  7, 2'b10, 2'b10, 2'b00, 2'b00, -1, -1, -1};
    vecs[10] = '{2'b01,  7, 2'b01, 2'b01, 2'b10, 2'b00, -1, -1, -1};  // opposite edges, same cycle
    vecs[11] = '{2'b00, 10, 2'b00, 2'b00, 2'b01, 2'b00, -1, -1, -1};

    // Reset state
    #3 rstn = 1'b0;
    step(3);
    check("rst_y", y, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_press", press, 0);
    check("rst_y_norep", y_n, 0);
    check("rst_y_pre", y_p, 0);
    #1 rstn = 1'b1;
    step(3);

    // Clean press and release on channel 0
    e = cyc;
    x = 2'b01;
    push_press(e + LAT, 0);
    step(LAT - 1);
    check("press_y_before", y, 2'b00);
    step(1);
    check("press_y_at", y, 2'b01);
    check("press_rise_at", rise, 2'b01);
    check("press_press_at", press, 2'b01);
    step(1);
    check("press_rise_after", rise, 2'b00);
    r = cyc;
    x = 2'b00;
    push(r + LAT, 0, EV_FALL);
    step(LAT - 1);
    check("release_y_before", y, 2'b01);
    step(1);
    check("release_y_at", y, 2'b00);
    check("release_fall_at", fall, 2'b01);
    check("release_press_at", press, 2'b00);
    step(1);
    check("release_fall_after", fall, 2'b00);
    step(4);

    // Bounce rejection: toggle every 2 cycles, then hold high
    for (int k = 0; k < 10; k++) begin
      x[0] = ~x[0];
      step(2);
      check("bounce_y_low", y, 2'b00);
    end
    x[0] = 1'b1;
    e = cyc;
    push_press(e + LAT, 0);
    step(LAT - 1);
    check("bounce_y_before", y, 2'b00);
    step(1);
    check("bounce_y_at", y, 2'b01);
    step(1);
    x[0] = 1'b0;
    push(cyc + LAT, 0, EV_FALL);
    step(10);
    check("bounce_y_end", y, 2'b00);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      e = cyc;
      x = vecs[i].x;
      for (int ch = 0; ch < N; ch++) begin
        if (vecs[i].rise_m[ch]) push_press(e + LAT, ch);
        if (vecs[i].fall_m[ch]) push(e + LAT, ch, EV_FALL);
        if (vecs[i].rep_m[ch]) begin
          if (vecs[i].r0 >= 0) push(e + vecs[i].r0, ch, EV_PRESS);
          if (vecs[i].r1 >= 0) push(e + vecs[i].r1, ch, EV_PRESS);
          if (vecs[i].r2 >= 0) push(e + vecs[i].r2, ch, EV_PRESS);
        end
      end
      step(vecs[i].hold);
      check($sformatf("vec%0d_y", i), y, vecs[i].y_end);
    end

    // Asynchronous reset while repeat counting is in progress
    e = cyc;
    x = 2'b01;
    push_press(e + LAT, 0);
    step(LAT + 5);
    check("midrst_y_pre", y, 2'b01);
    #1 rstn = 1'b0;
    #1;
    check("midrst_y_now", y, 0);
    check("midrst_rise_now", rise, 0);
    check("midrst_fall_now", fall, 0);
    check("midrst_press_now", press, 0);
    step(2);
    check("midrst_y_held", y, 0);
    #1 rstn = 1'b1;
    r = cyc;
    push_press(r + LAT, 0);
    push(r + LAT + RD, 0, EV_PRESS);
    push(r + LAT + RD + RR, 0, EV_PRESS);
    push(r + LAT + RD + 2 * RR, 0, EV_PRESS);
    step(LAT - 1);
    check("midrst_y_before", y, 2'b00);
    step(1);
    check("midrst_y_at", y, 2'b01);
    step(9);
    x = 2'b00;
    push(cyc + LAT, 0, EV_FALL);
    step(10);
    check("midrst_y_end", y, 2'b00);

    // Prescaled DUT: latency window at random tick phase
    for (int it = 0; it < 4; it++) begin
      step($urandom_range(1, 7));
      xp[0] = 1'b1;
      d = 0;
      while (y_p[0] !== 1'b1 && d < 40) begin step(1); d++; end
      check_rng("pre_rise_latency", d, 18, 22);
      xp[0] = 1'b0;
      d = 0;
      while (y_p[0] !== 1'b0 && d < 40) begin step(1); d++; end
      check_rng("pre_fall_latency", d, 18, 22);
    end

    // Single-cycle glitch mid-count restarts the prescaled count
    step(3);
    xp[0] = 1'b1;
    step(10);
    xp[0] = 1'b0;
    step(1);
    xp[0] = 1'b1;
    d = 0;
    while (y_p[0] !== 1'b1 && d < 40) begin step(1); d++; end
    check_rng("pre_glitch_latency", d, 18, 22);
    xp[0] = 1'b0;
    d = 0;
    while (y_p[0] !== 1'b0 && d < 40) begin step(1); d++; end
    check_rng("pre_glitch_fall_latency", d, 18, 22);

    // Drain and totals
    step(12);
    check("sb_pending", sb.size(), 0);
    check("norep_rise_total", nr_cnt, exp_rise_total);
    check("norep_press_total", np_cnt, exp_rise_total);
    check("norep_fall_total", nf_cnt, exp_fall_total);
    check("norep_y_final", y_n, 0);
    check("pre_rise_total", pr_cnt, 5);
    check("pre_fall_total", pf_cnt, 5);
    check("pre_press_total", pp_cnt, 5);
    check("pre_y_final", y_p, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
